// File: rtl/mipspkg.sv
// Shared processor/memory interface types and constants.
// Pure declarations: no logic, no latency.
// No flow control lives here; users apply their own.
package mipspkg;

    localparam int WORD_BYTES = 4;
    localparam int MEM_ADDR_W = 10;

    // Posted store as held in the memory-side write buffer.
    typedef struct packed {
        logic [MEM_ADDR_W-1:0] addr;
        logic [31:0]           data;
    } wb_entry_t;

endpackage

// File: rtl/membuf_fifo.sv
// Write-buffer FIFO of wb_entry_t with a youngest-match search port.
// Latency: push visible on head/search the cycle after; search is combinational.
// Backpressure: push while full is accepted only together with a pop; otherwise ignored.
module membuf_fifo
    import mipspkg::*;
#(
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  wb_entry_t             push_entry,
    input  logic                  pop,
    output wb_entry_t             head,
    output logic [CW-1:0]         count,
    output logic                  full,
    input  logic [MEM_ADDR_W-1:0] search_addr,
    output logic                  hit,
    output logic [31:0]           hit_data
);

    wb_entry_t          entries [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               push_ok;
    logic               pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign pop_ok  = pop && (count != '0);
    assign push_ok = push && (!full || pop_ok);
    assign head    = entries[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            entries[wr_ptr] <= push_entry;
        end
    end

    // Walk oldest to youngest so the last match found is the youngest.
    always_comb begin
        logic [PTR_W-1:0] idx;
        hit      = 1'b0;
        hit_data = '0;
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PTR_W'(i);
            if ((CW'(i) < count) && (entries[idx].addr == search_addr)) begin
                hit      = 1'b1;
                hit_data = entries[idx].data;
            end
        end
    end

endmodule

// File: rtl/proc_mem_responder.sv
// Memory-side responder: unified word array, posted-store buffer, host loader port.
// Latency: instr/readdata combinational; stores forwarded next cycle, drained >=1 cycle later.
// Backpressure: none to the core; stores arriving on a full, non-draining buffer are dropped (overflow).
module proc_mem_responder
    import mipspkg::*;
#(
    parameter int ADDR_W   = 10,
    parameter int WB_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [31:0]                      pc,
    output logic [31:0]                      instr,
    input  logic [31:0]                      dataadr,
    input  logic [31:0]                      writedata,
    input  logic                             memwrite,
    output logic [31:0]                      readdata,
    input  logic                             host_we,
    input  logic [ADDR_W-1:0]                host_addr,
    input  logic [31:0]                      host_wdata,
    output logic [$clog2(WB_DEPTH+1)-1:0]    wb_count,
    output logic                             wb_full,
    output logic                             overflow,
    output logic                             misalign
);

    localparam int OFF_W = $clog2(WORD_BYTES);

    logic [31:0]        mem [2**ADDR_W];
    logic [ADDR_W-1:0]  d_idx;
    logic [ADDR_W-1:0]  i_idx;
    wb_entry_t          push_entry;
    wb_entry_t          head;
    logic               drain;
    logic               hit;
    logic [31:0]        hit_data;
    logic               unused_addr_bits;

    assign d_idx = dataadr[ADDR_W+OFF_W-1:OFF_W];
    assign i_idx = pc[ADDR_W+OFF_W-1:OFF_W];
    assign unused_addr_bits = ^{pc[31:ADDR_W+OFF_W], pc[OFF_W-1:0], dataadr[31:ADDR_W+OFF_W]};

    assign push_entry.addr = d_idx;
    assign push_entry.data = writedata;

    // Host owns the array write port; the buffer drains only on host-idle cycles.
    assign drain = (wb_count != '0) && !host_we && !reset;

    membuf_fifo #(
        .DEPTH (WB_DEPTH)
    ) u_wbuf (
        .clk         (clk),
        .reset       (reset),
        .push        (memwrite && !reset),
        .push_entry  (push_entry),
        .pop         (drain),
        .head        (head),
        .count       (wb_count),
        .full        (wb_full),
        .search_addr (d_idx),
        .hit         (hit),
        .hit_data    (hit_data)
    );

    always_ff @(posedge clk) begin
        if (host_we) begin
            mem[host_addr] <= host_wdata;
        end else if (drain) begin
            mem[head.addr] <= head.data;
        end
    end

    assign instr    = mem[i_idx];
    assign readdata = hit ? hit_data : mem[d_idx];

    // The data read index is live every cycle, so a misaligned dataadr counts even without a store.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
            misalign <= 1'b0;
        end else begin
            if (memwrite && wb_full && !drain) begin
                overflow <= 1'b1;
            end
            if (dataadr[OFF_W-1:0] != '0) begin
                misalign <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_proc_mem_responder.sv
// Randomized + directed bench for proc_mem_responder against a queue/array model.
module tb_proc_mem_responder;

    localparam int ADDR_W   = 10;
    localparam int WB_DEPTH = 4;
    localparam int DEPTH_W  = 2**ADDR_W;

    logic                           clk;
    logic                           reset;
    logic [31:0]                    pc;
    logic [31:0]                    instr;
    logic [31:0]                    dataadr;
    logic [31:0]                    writedata;
    logic                           memwrite;
    logic [31:0]                    readdata;
    logic                           host_we;
    logic [ADDR_W-1:0]              host_addr;
    logic [31:0]                    host_wdata;
    logic [$clog2(WB_DEPTH+1)-1:0]  wb_count;
    logic                           wb_full;
    logic                           overflow;
    logic                           misalign;

    proc_mem_responder #(
        .ADDR_W   (ADDR_W),
        .WB_DEPTH (WB_DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pc         (pc),
        .instr      (instr),
        .dataadr    (dataadr),
        .writedata  (writedata),
        .memwrite   (memwrite),
        .readdata   (readdata),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .wb_count   (wb_count),
        .wb_full    (wb_full),
        .overflow   (overflow),
        .misalign   (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    typedef struct {
        int unsigned addr;
        logic [31:0] data;
    } ent_t;

    ent_t        q[$];
    logic [31:0] mmem  [DEPTH_W];
    bit          known [DEPTH_W];
    bit          m_ovf;
    bit          m_mis;
    bit          cmp_en;
    int          n_cmp;
    int          n_err;

    function automatic int unsigned widx(input logic [31:0] a);
        return (a / 4) % DEPTH_W;
    endfunction

    function automatic bit model_rd_known(input int unsigned a);
        foreach (q[i]) if (q[i].addr == a) return 1'b1;
        return known[a];
    endfunction

    function automatic logic [31:0] model_rd(input int unsigned a);
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].addr == a) return q[i].data;
        end
        return mmem[a];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        bit drain_now;
        bit was_full;
        if (host_we) begin
            mmem[host_addr]  = host_wdata;
            known[host_addr] = 1'b1;
        end
        if (reset) begin
            q.delete();
            m_ovf = 1'b0;
            m_mis = 1'b0;
        end else begin
            drain_now = (q.size() > 0) && !host_we;
            was_full  = (q.size() == WB_DEPTH);
            if (drain_now) begin
                mmem[q[0].addr]  = q[0].data;
                known[q[0].addr] = 1'b1;
                void'(q.pop_front());
            end
            if (memwrite) begin
                if (!was_full || drain_now) q.push_back('{widx(dataadr), writedata});
                else m_ovf = 1'b1;
            end
            if (dataadr % 4 != 0) m_mis = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("wb_count", 32'(wb_count), 32'(q.size()));
            chk("wb_full", 32'(wb_full), 32'(q.size() == WB_DEPTH));
            chk("overflow", 32'(overflow), 32'(m_ovf));
            chk("misalign", 32'(misalign), 32'(m_mis));
            if (model_rd_known(widx(dataadr))) chk("readdata", readdata, model_rd(widx(dataadr)));
            if (known[widx(pc)]) chk("instr", instr, mmem[widx(pc)]);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] saved;
        logic [31:0] r;
        n_cmp = 0;
        n_err = 0;
        cmp_en = 1'b0;
        m_ovf = 1'b0;
        m_mis = 1'b0;
        for (int i = 0; i < DEPTH_W; i++) known[i] = 1'b0;
        reset = 1'b1; pc = '0; dataadr = '0; writedata = '0; memwrite = 1'b0;
        host_we = 1'b0; host_addr = '0; host_wdata = '0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        cmp_en = 1'b1;
        chk("reset_wb_count", 32'(wb_count), 32'd0);
        chk("reset_wb_full", 32'(wb_full), 32'd0);
        chk("reset_overflow", 32'(overflow), 32'd0);
        chk("reset_misalign", 32'(misalign), 32'd0);

        // preload the whole array through the host port
        for (int i = 0; i < DEPTH_W; i++) begin
            host_we = 1'b1; host_addr = ADDR_W'(i); host_wdata = $urandom;
            tick();
        end
        host_we = 1'b0;

        // host preload then fetch/load
        host_we = 1'b1; host_addr = 10'd5; host_wdata = 32'hDEADBEEF;
        tick();
        host_we = 1'b0; pc = 32'h14; dataadr = 32'h14;
        #1;
        chk("t1_instr", instr, 32'hDEADBEEF);
        chk("t1_readdata", readdata, 32'hDEADBEEF);

        // store then forwarded load, then drain to array
        dataadr = 32'h20; writedata = 32'h11111111; memwrite = 1'b1;
        tick();
        memwrite = 1'b0;
        #1;
        chk("t2_forward", readdata, 32'h11111111);
        chk("t2_count1", 32'(wb_count), 32'd1);
        tick();
        pc = 32'h20;
        #1;
        chk("t2_count0", 32'(wb_count), 32'd0);
        chk("t2_array", instr, 32'h11111111);

        // two stores to one word while host blocks the drain
        host_we = 1'b1; host_addr = 10'h3FF; host_wdata = 32'h0;
        dataadr = 32'h20; writedata = 32'hA; memwrite = 1'b1;
        tick();
        writedata = 32'hB;
        tick();
        memwrite = 1'b0;
        #1;
        chk("t3_youngest", readdata, 32'hB);
        chk("t3_count", 32'(wb_count), 32'd2);
        host_we = 1'b0;
        tick();
        tick();
        #1;
        chk("t3_array", instr, 32'hB);
        chk("t3_drained", 32'(wb_count), 32'd0);

        // fill to full with the drain blocked, fifth store dropped
        host_we = 1'b1; host_addr = 10'h3FE; host_wdata = 32'h0;
        for (int i = 0; i < 5; i++) begin
            dataadr = 32'h40 + 32'(4 * i); writedata = 32'h100 + 32'(i); memwrite = 1'b1;
            tick();
            #1;
            if (i == 3) begin
                chk("t4_full", 32'(wb_full), 32'd1);
                chk("t4_no_ovf_yet", 32'(overflow), 32'd0);
            end
        end
        memwrite = 1'b0;
        chk("t4_overflow", 32'(overflow), 32'd1);
        chk("t4_count", 32'(wb_count), 32'd4);
        host_we = 1'b0;
        repeat (5) tick();
        chk("t4_sticky", 32'(overflow), 32'd1);
        chk("t4_empty", 32'(wb_count), 32'd0);

        // reset with three stores pending discards them
        saved = mmem[24];
        host_we = 1'b1; host_addr = 10'h3FD; host_wdata = 32'h0;
        for (int i = 0; i < 3; i++) begin
            dataadr = 32'h60 + 32'(4 * i); writedata = 32'hC0DE0000 + 32'(i); memwrite = 1'b1;
            tick();
        end
        memwrite = 1'b0;
        #1;
        chk("t5_count3", 32'(wb_count), 32'd3);
        reset = 1'b1;
        tick();
        reset = 1'b0; host_we = 1'b0; dataadr = 32'h60;
        #1;
        chk("t5_count0", 32'(wb_count), 32'd0);
        chk("t5_ovf_clr", 32'(overflow), 32'd0);
        chk("t5_old_data", readdata, saved);
        repeat (3) tick();
        chk("t5_array_kept", readdata, saved);

        // misaligned store and address aliasing
        dataadr = 32'h22; writedata = 32'h12345678; memwrite = 1'b1;
        tick();
        memwrite = 1'b0; dataadr = 32'h20;
        #1;
        chk("t6_misalign", 32'(misalign), 32'd1);
        chk("t6_forward", readdata, 32'h12345678);
        tick();
        pc = 32'h20; dataadr = 32'h1014;
        #1;
        chk("t6_array", instr, 32'h12345678);
        chk("t6_alias", readdata, 32'hDEADBEEF);

        // randomized traffic on a small address window
        for (int c = 0; c < 4000; c++) begin
            r = $urandom;
            memwrite   = ($urandom % 2) == 0;
            host_we    = ($urandom % 4) == 0;
            host_addr  = ADDR_W'($urandom_range(0, 15));
            host_wdata = $urandom;
            writedata  = $urandom;
            reset      = ($urandom % 300) == 0;
            dataadr    = {r[31:12], 6'd0, 4'($urandom_range(0, 15)), 2'b00};
            if (memwrite && ($urandom % 8) == 0) dataadr[1:0] = 2'($urandom_range(1, 3));
            r  = $urandom;
            pc = {r[31:12], 6'd0, 4'($urandom_range(0, 15)), 2'b00};
            tick();
        end
        reset = 1'b0; memwrite = 1'b0; host_we = 1'b0;
        repeat (6) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
